// File: rtl/dcache_lru_ctrl.sv
// Two-way, 16-set write-back data cache controller with one LRU bit per set.
// Tags and state bits live here; line data lives in an external SRAM.
module dcache_lru_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [3:0]   sram_idx_o,
    output logic         sram_way_o,
    output logic         sram_we_o,
    output logic [255:0] sram_wdata_o,
    input  logic [255:0] sram_rdata_i,
    output logic         mem_req_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_t;

    function automatic logic [31:0] get_word(input logic [255:0] line, input logic [2:0] w);
        logic [7:0][31:0] v;
        v = line;
        return v[w];
    endfunction

    function automatic logic [255:0] put_word(input logic [255:0] line, input logic [2:0] w,
                                              input logic [31:0] d);
        logic [7:0][31:0] v;
        v    = line;
        v[w] = d;
        return v;
    endfunction

    state_t state_q, state_d;

    logic [1:0][15:0][22:0] tag_q;
    logic [1:0][15:0]       valid_q, dirty_q;
    logic [15:0]            lru_q;

    logic [31:2] addr_q;
    logic        write_q;
    logic [31:0] data_q;
    logic        victim_q;

    logic [3:0]  idx, idx_q;
    logic [22:0] tag;
    logic [2:0]  word;
    logic        hit0, hit1, hit, hit_way, victim_sel;
    logic        hit_upd, latch, fill, upd_lru;
    logic        unused_bits;

    assign idx         = cpu_addr_i[8:5];
    assign tag         = cpu_addr_i[31:9];
    assign word        = cpu_addr_i[4:2];
    assign idx_q       = addr_q[8:5];
    assign unused_bits = ^cpu_addr_i[1:0];

    assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = ~hit0;
    // Fill empty ways in order before evicting anything.
    assign victim_sel = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            lru_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            data_q   <= '0;
            victim_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hit_upd) begin
                lru_q[idx] <= ~hit_way;
                if (cpu_write_i) dirty_q[hit_way][idx] <= 1'b1;
            end
            if (latch) begin
                addr_q   <= cpu_addr_i[31:2];
                write_q  <= cpu_write_i;
                data_q   <= cpu_data_i;
                victim_q <= victim_sel;
            end
            if (fill) begin
                tag_q[victim_q][idx_q]   <= addr_q[31:9];
                valid_q[victim_q][idx_q] <= 1'b1;
                dirty_q[victim_q][idx_q] <= write_q;
            end
            if (upd_lru) lru_q[idx_q] <= ~victim_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cpu_data_o   = '0;
        cpu_stall_o  = 1'b0;
        sram_idx_o   = '0;
        sram_way_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_wdata_o = '0;
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        hit_upd      = 1'b0;
        latch        = 1'b0;
        fill         = 1'b0;
        upd_lru      = 1'b0;
        case (state_q)
            IDLE: begin
                sram_idx_o = idx;
                sram_way_o = hit ? hit_way : victim_sel;
                if (cpu_req_i) begin
                    if (hit) begin
                        hit_upd    = 1'b1;
                        cpu_data_o = get_word(sram_rdata_i, word);
                        if (cpu_write_i) begin
                            sram_we_o    = 1'b1;
                            sram_wdata_o = put_word(sram_rdata_i, word, cpu_data_i);
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        latch       = 1'b1;
                        state_d     = (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx])
                                      ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                sram_idx_o  = idx_q;
                sram_way_o  = victim_q;
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {tag_q[victim_q][idx_q], idx_q, 5'b0};
                mem_data_o  = sram_rdata_i;
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                sram_idx_o  = idx_q;
                sram_way_o  = victim_q;
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {addr_q[31:9], idx_q, 5'b0};
                if (mem_ack_i) begin
                    sram_we_o    = 1'b1;
                    sram_wdata_o = write_q ? put_word(mem_data_i, addr_q[4:2], data_q) : mem_data_i;
                    fill         = 1'b1;
                    state_d      = UPDATE;
                end
            end
            UPDATE: begin
                // Line was written last cycle; read it back to return the requested word.
                sram_idx_o = idx_q;
                sram_way_o = victim_q;
                cpu_data_o = get_word(sram_rdata_i, addr_q[4:2]);
                upd_lru    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            cpu_data_o   = '0;
            cpu_stall_o  = 1'b0;
            sram_idx_o   = '0;
            sram_way_o   = 1'b0;
            sram_we_o    = 1'b0;
            sram_wdata_o = '0;
            mem_req_o    = 1'b0;
            mem_write_o  = 1'b0;
            mem_addr_o   = '0;
            mem_data_o   = '0;
        end
    end

endmodule

// File: tb/tb_dcache_lru_ctrl.sv
// Random/directed bench for dcache_lru_ctrl: architectural memory image plus timestamp-LRU cache model.
module tb_dcache_lru_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_idx_o;
    logic         sram_way_o, sram_we_o;
    logic [255:0] sram_wdata_o, sram_rdata_i;
    logic         mem_req_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_ack_i;

    always #5 clk_i = ~clk_i;

    dcache_lru_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_idx_o(sram_idx_o), .sram_way_o(sram_way_o), .sram_we_o(sram_we_o),
        .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    // External data array: combinational read, clocked line write.
    logic [255:0] sram [16][2];
    assign sram_rdata_i = sram[sram_idx_o][sram_way_o];
    always @(posedge clk_i) if (sram_we_o) sram[sram_idx_o][sram_way_o] <= sram_wdata_o;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Backing memory and architectural (CPU-visible) image, both word addressed.
    logic [31:0] mem_img [logic [31:0]];
    logic [31:0] gold    [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_img.exists(a) ? mem_img[a] : init_word(a);
    endfunction
    function automatic logic [31:0] gold_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return gold.exists(wa) ? gold[wa] : init_word(wa);
    endfunction
    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word({a[31:5], 3'(i), 2'b00});
        return l;
    endfunction
    function automatic logic [255:0] gold_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold_word({a[31:5], 3'(i), 2'b00});
        return l;
    endfunction

    // Cache model: residency per way, replacement by oldest use time.
    bit          m_valid [16][2];
    bit          m_dirty [16][2];
    logic [22:0] m_tag   [16][2];
    int          m_time  [16][2];
    int          tick;

    task automatic m_reset();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0; m_time[s][w] = 0;
            end
    endtask

    function automatic int m_lookup(input logic [31:0] a);
        int s;
        s = int'(a[8:5]);
        for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == a[31:9]) return w;
        return -1;
    endfunction

    task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input int delay, input bit drop, input bit rst_mode);
        int s, hw, vw, cyc, mdelay, mwait;
        bit exp_wb, wb_seen, rf_seen, done, aborted, mactive, s_wr;
        logic [31:0] wb_addr, s_addr;
        logic [255:0] s_data;
        s  = int'(addr[8:5]);
        hw = m_lookup(addr);
        vw = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : (m_time[s][0] < m_time[s][1] ? 0 : 1));
        exp_wb  = (hw < 0) && m_valid[s][vw] && m_dirty[s][vw];
        wb_addr = {m_tag[s][vw], addr[8:5], 5'b0};
        wb_seen = 0; rf_seen = 0; done = 0; aborted = 0; mactive = 0;
        mdelay = 0; mwait = 0; s_wr = 0; s_addr = '0; s_data = '0; cyc = 0;
        cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = addr; cpu_data_i = data;
        while (!done && cyc < 100) begin
            @(negedge clk_i);
            if (cyc == 0) chk("hit", !cpu_stall_o, hw >= 0);
            if (!cpu_stall_o) begin
                if (!wr) chk("rdata", cpu_data_o, gold_word(addr));
                if (cyc > 0) begin
                    chk("mreq_low_update", mem_req_o, 0);
                    chk("wb_seen", wb_seen, exp_wb);
                    chk("rf_seen", rf_seen, 1);
                end
                done = 1;
            end else if (mem_req_o) begin
                if (!mactive) begin
                    mactive = 1; s_addr = mem_addr_o; s_wr = mem_write_o; s_data = mem_data_o;
                    mdelay = (delay >= 0) ? delay : int'($urandom_range(0, 3));
                    mwait = 0;
                    if (s_wr) begin
                        wb_seen = 1;
                        chk("wb_addr", mem_addr_o, wb_addr);
                        chk("wb_data", mem_data_o, gold_line(wb_addr));
                    end else begin
                        rf_seen = 1;
                        chk("rf_addr", mem_addr_o, {addr[31:5], 5'b0});
                        if (rst_mode) begin
                            rst_i = 1'b1;
                            #1;
                            chk("rst_ctl", {cpu_stall_o, mem_req_o, mem_write_o, sram_we_o,
                                            sram_way_o, sram_idx_o}, 0);
                            chk("rst_bus", {cpu_data_o, mem_addr_o}, 0);
                            chk("rst_wide", {|sram_wdata_o, |mem_data_o}, 0);
                            aborted = 1;
                            break;
                        end
                    end
                end else begin
                    chk("mem_addr_stable", mem_addr_o, s_addr);
                    chk("mem_wr_stable", mem_write_o, s_wr);
                    if (s_wr) chk("mem_data_stable", mem_data_o, s_data);
                end
                if (mwait == mdelay) begin
                    mem_ack_i = 1'b1;
                    if (s_wr) begin
                        for (int i = 0; i < 8; i++)
                            mem_img[{s_addr[31:5], 3'(i), 2'b00}] = s_data[i*32 +: 32];
                    end else begin
                        mem_data_i = mem_line(s_addr);
                    end
                    mactive = 0;
                end
                mwait++;
            end else if (mactive) begin
                chk("mem_req_held", mem_req_o, 1);
            end
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            if (drop && cyc == 0) begin
                cpu_req_i = 1'b0; cpu_addr_i = $urandom; cpu_write_i = 1'b0; cpu_data_i = $urandom;
            end
            cyc++;
        end
        if (aborted) begin
            @(posedge clk_i); #1;
            chk("rst_we_hold", sram_we_o, 0);
            cpu_req_i = 1'b0; mem_ack_i = 1'b0;
            @(negedge clk_i);
            rst_i = 1'b0;
            m_reset();
            gold = mem_img;
            @(posedge clk_i); #1;
            return;
        end
        if (!done) chk("access_timeout", 0, 1);
        cpu_req_i = 1'b0;
        if (hw >= 0) begin
            m_time[s][hw] = ++tick;
            if (wr) m_dirty[s][hw] = 1;
        end else begin
            m_valid[s][vw] = 1; m_tag[s][vw] = addr[31:9]; m_dirty[s][vw] = wr; m_time[s][vw] = ++tick;
        end
        if (wr) gold[{addr[31:2], 2'b00}] = data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 2; w++) sram[s][w] = {8{$urandom}};
        rst_i = 1'b1; cpu_req_i = 1'b1; cpu_write_i = 1'b1; cpu_addr_i = 32'h40;
        cpu_data_i = 32'h1; mem_ack_i = 1'b1; mem_data_i = '1;
        tick = 0;
        m_reset();
        #12;
        chk("reset_ctl", {cpu_stall_o, mem_req_o, mem_write_o, sram_we_o, sram_way_o, sram_idx_o}, 0);
        chk("reset_bus", {cpu_data_o, mem_addr_o}, 0);
        chk("reset_wide", {|sram_wdata_o, |mem_data_o}, 0);
        cpu_req_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk_i) rst_i = 1'b0;
        @(posedge clk_i); #1;

        do_access(0, 32'h40, 0, 3, 0, 0);             // cold miss, refill
        do_access(0, 32'h40, 0, -1, 0, 0);            // repeat hits
        do_access(1, 32'h44, 32'hDEADBEEF, -1, 0, 0); // write hit
        do_access(0, 32'h44, 0, -1, 0, 0);
        do_access(0, 32'h240, 0, -1, 0, 0);           // second way of set 2
        do_access(0, 32'h40, 0, -1, 0, 0);            // touch
        do_access(0, 32'h440, 0, -1, 0, 0);           // evicts clean 0x240
        do_access(1, 32'h240, 32'h1234_5678, -1, 0, 0);
        do_access(0, 32'h40, 0, -1, 0, 0);
        do_access(0, 32'h440, 0, 5, 0, 0);            // dirty 0x240 written back, slow ack
        do_access(0, 32'h248, 0, -1, 0, 0);
        do_access(0, 32'h1A60, 0, 2, 0, 1);           // reset during refill
        do_access(0, 32'h1A60, 0, -1, 0, 0);          // must miss again
        do_access(0, 32'h3C80, 0, 4, 1, 0);           // request dropped mid-miss
        do_access(0, 32'h3C84, 0, -1, 0, 0);          // line now resident

        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = {21'(0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 3'($urandom), 2'b00};
            do_access(1'($urandom_range(0, 1)), a, $urandom, -1, n % 37 == 5, 0);
            if ($urandom_range(0, 4) == 0) begin
                mem_ack_i = 1'b1;
                @(posedge clk_i); #1;
                mem_ack_i = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
